// File: rtl/prod_err_pkg.sv
// Shared types, default widths and width helpers for the product-error accumulator.
package prod_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_BIT_WIDTH   = 8;
    localparam int DEF_OUT_WIDTH   = 2 * DEF_BIT_WIDTH;
    localparam int DEF_NUM_SAMPLES = 1024;

    // Wide enough that num_samples worst-case errors can never overflow the sum.
    function automatic int acc_width(input int out_width, input int num_samples);
        return out_width + $clog2(num_samples);
    endfunction

endpackage

// File: rtl/prod_err_diff.sv
// Two-stage pipe: S1 registers the exact product and the returned product,
// S2 registers the absolute difference. Valid bits carry bubbles through.
module prod_err_diff
    import prod_err_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [OUT_WIDTH-1:0] in_prod,
    output logic                 diff_valid,
    output logic [OUT_WIDTH-1:0] diff
);

    logic                 s1_valid_reg;
    logic [OUT_WIDTH-1:0] exact_reg;
    logic [OUT_WIDTH-1:0] prod_reg;
    logic                 s2_valid_reg;
    logic [OUT_WIDTH-1:0] diff_reg;
    logic [OUT_WIDTH:0]   delta;
    logic [OUT_WIDTH:0]   delta_neg;
    logic [OUT_WIDTH-1:0] diff_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            exact_reg    <= '0;
            prod_reg     <= '0;
        end else if (clear) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                exact_reg <= OUT_WIDTH'(in_a) * OUT_WIDTH'(in_b);
                prod_reg  <= in_prod;
            end
        end
    end

    // One extra bit so that out > exact is seen as a negative difference.
    assign delta     = {1'b0, exact_reg} - {1'b0, prod_reg};
    assign delta_neg = -delta;
    assign diff_next = delta[OUT_WIDTH] ? delta_neg[OUT_WIDTH-1:0] : delta[OUT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg <= 1'b0;
            diff_reg     <= '0;
        end else if (clear) begin
            s2_valid_reg <= 1'b0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                diff_reg <= diff_next;
            end
        end
    end

    assign diff_valid = s2_valid_reg;
    assign diff       = diff_reg;

endmodule

// File: rtl/prod_err_accum.sv
// Windowed error statistics for an approximate multiplier: sum, max and count of
// nonzero |a*b - out|. Define PROD_ERR_SQ_EN to add the err_sq_sum output (S3 stage).
module prod_err_accum
    import prod_err_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int ACC_W       = acc_width(OUT_WIDTH, NUM_SAMPLES),
    parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic [OUT_WIDTH-1:0] out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_W-1:0]     err_sum,
    output logic [OUT_WIDTH-1:0] err_max,
`ifdef PROD_ERR_SQ_EN
    output logic [2*OUT_WIDTH+$clog2(NUM_SAMPLES)-1:0] err_sq_sum,
`endif
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES);

    state_t               state_reg;
    logic [CNT_W-1:0]     accepted_reg;
    logic [CNT_W-1:0]     done_cnt_reg;
    logic [ACC_W-1:0]     sum_reg;
    logic [OUT_WIDTH-1:0] max_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 take;
    logic                 res_take;
    logic                 d_valid;
    logic [OUT_WIDTH-1:0] d_diff;
    logic                 acc_valid;
    logic [OUT_WIDTH-1:0] acc_diff;

    assign in_ready  = (state_reg == IDLE) || ((state_reg == RUN) && (accepted_reg < LAST));
    assign take      = in_valid && in_ready && !clear;
    assign res_valid = (state_reg == DONE);
    assign res_take  = res_valid && res_ready;

    prod_err_diff #(
        .BIT_WIDTH (BIT_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_diff (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (take),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_prod    (out),
        .diff_valid (d_valid),
        .diff       (d_diff)
    );

`ifdef PROD_ERR_SQ_EN
    localparam int SQ_W = 2*OUT_WIDTH + $clog2(NUM_SAMPLES);
    localparam int PW   = 2*OUT_WIDTH;

    logic                 s3_valid_reg;
    logic [OUT_WIDTH-1:0] s3_diff_reg;
    logic [PW-1:0]        s3_sq_reg;
    logic [SQ_W-1:0]      sq_sum_reg;

    // The square gets its own register stage; diff is delayed alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_reg <= 1'b0;
            s3_diff_reg  <= '0;
            s3_sq_reg    <= '0;
        end else if (clear) begin
            s3_valid_reg <= 1'b0;
        end else begin
            s3_valid_reg <= d_valid;
            if (d_valid) begin
                s3_diff_reg <= d_diff;
                s3_sq_reg   <= PW'(d_diff) * PW'(d_diff);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_sum_reg <= '0;
        end else if (clear || res_take) begin
            sq_sum_reg <= '0;
        end else if (s3_valid_reg) begin
            sq_sum_reg <= sq_sum_reg + SQ_W'(s3_sq_reg);
        end
    end

    assign acc_valid  = s3_valid_reg;
    assign acc_diff   = s3_diff_reg;
    assign err_sq_sum = sq_sum_reg;
`else
    assign acc_valid = d_valid;
    assign acc_diff  = d_diff;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg      <= '0;
            max_reg      <= '0;
            cnt_reg      <= '0;
            done_cnt_reg <= '0;
        end else if (clear || res_take) begin
            sum_reg      <= '0;
            max_reg      <= '0;
            cnt_reg      <= '0;
            done_cnt_reg <= '0;
        end else if (acc_valid) begin
            sum_reg      <= sum_reg + ACC_W'(acc_diff);
            if (acc_diff > max_reg) begin
                max_reg <= acc_diff;
            end
            if (acc_diff != '0) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            done_cnt_reg <= done_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            accepted_reg <= '0;
        end else if (clear) begin
            state_reg    <= IDLE;
            accepted_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (take) begin
                    accepted_reg <= CNT_W'(1);
                    state_reg    <= (NUM_SAMPLES == 1) ? DRAIN : RUN;
                end
                RUN: if (take) begin
                    accepted_reg <= accepted_reg + CNT_W'(1);
                    if (accepted_reg + CNT_W'(1) == LAST) begin
                        state_reg <= DRAIN;
                    end
                end
                // Waiting on the registered count adds the cycle that aligns res_valid.
                DRAIN: if (done_cnt_reg == LAST) begin
                    state_reg <= DONE;
                end
                DONE: if (res_ready) begin
                    state_reg    <= IDLE;
                    accepted_reg <= '0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign err_sum = sum_reg;
    assign err_max = max_reg;
    assign err_cnt = cnt_reg;

endmodule

// File: tb/tb_prod_err_accum.sv
// Bench for prod_err_accum: three instances (windows of 4, 2 and 1024) against a
// window-level model, plus literal expectations for the directed windows.
module tb_prod_err_accum;

    localparam int NI = 3;
`ifdef PROD_ERR_SQ_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    function automatic int ns_of(input int i);
        case (i)
            0:       return 4;
            1:       return 2;
            default: return 1024;
        endcase
    endfunction

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld    [NI];
    logic        clr    [NI];
    logic        rdy    [NI];
    logic [7:0]  a_in   [NI];
    logic [7:0]  b_in   [NI];
    logic [15:0] p_in   [NI];
    logic        iready [NI];
    logic        rvalid [NI];
    logic [47:0] sum_o  [NI];
    logic [15:0] max_o  [NI];
    logic [15:0] cnt_o  [NI];
`ifdef PROD_ERR_SQ_EN
    logic [63:0] sq_o   [NI];
`endif

    int     n_cmp = 0;
    int     n_bad = 0;
    int     m_acc  [NI];
    int     m_lat  [NI];
    bit     m_done [NI];
    longint m_sum  [NI];
    longint m_sq   [NI];
    longint m_max  [NI];
    longint m_cnt  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int N = ns_of(gi);
        logic [16+$clog2(N)-1:0] s_w;
        logic [$clog2(N+1)-1:0]  c_w;
        logic [15:0]             m_w;
        logic                    ir_w;
        logic                    rv_w;
`ifdef PROD_ERR_SQ_EN
        logic [32+$clog2(N)-1:0] q_w;
`endif
        prod_err_accum #(
            .BIT_WIDTH   (8),
            .OUT_WIDTH   (16),
            .NUM_SAMPLES (N)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .clear     (clr[gi]),
            .in_valid  (vld[gi]),
            .in_ready  (ir_w),
            .in_a      (a_in[gi]),
            .in_b      (b_in[gi]),
            .out       (p_in[gi]),
            .res_valid (rv_w),
            .res_ready (rdy[gi]),
            .err_sum   (s_w),
            .err_max   (m_w),
`ifdef PROD_ERR_SQ_EN
            .err_sq_sum(q_w),
`endif
            .err_cnt   (c_w)
        );
        assign iready[gi] = ir_w;
        assign rvalid[gi] = rv_w;
        assign sum_o[gi]  = 48'(s_w);
        assign max_o[gi]  = m_w;
        assign cnt_o[gi]  = 16'(c_w);
`ifdef PROD_ERR_SQ_EN
        assign sq_o[gi]   = 64'(q_w);
`endif
    end

    task automatic chk(input int i, input string nm, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d]: got %0d, want %0d", nm, i, got, exp);
        end
    endtask

    function automatic longint dif(input int a, input int b, input int p);
        longint e = longint'(a) * longint'(b);
        return (e > longint'(p)) ? e - longint'(p) : longint'(p) - e;
    endfunction

    task automatic mreset(input int i);
        m_acc[i] = 0; m_lat[i] = -1; m_done[i] = 1'b0;
        m_sum[i] = 0; m_sq[i] = 0; m_max[i] = 0; m_cnt[i] = 0;
    endtask

    // Window-level model: totals of accepted samples, result LAT edges after the window fills.
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (!rst_n || clr[i] || (m_done[i] && rdy[i])) begin
                mreset(i);
            end else begin
                if (m_lat[i] >= 0 && !m_done[i]) begin
                    m_lat[i]++;
                    if (m_lat[i] == LAT) m_done[i] = 1'b1;
                end
                if (vld[i] && m_acc[i] < ns_of(i)) begin
                    longint d = dif(int'(a_in[i]), int'(b_in[i]), int'(p_in[i]));
                    m_sum[i] += d;
                    m_sq[i]  += d * d;
                    if (d > m_max[i]) m_max[i] = d;
                    if (d != 0) m_cnt[i]++;
                    m_acc[i]++;
                    if (m_acc[i] == ns_of(i)) m_lat[i] = 0;
                end
            end
        end
    endtask

    // Checks every instance's outputs once per cycle, on the falling edge.
    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk(i, "in_ready", longint'(iready[i]), longint'(m_acc[i] < ns_of(i)));
            chk(i, "res_valid", longint'(rvalid[i]), longint'(m_done[i]));
            if (m_done[i] || m_acc[i] == 0) begin
                chk(i, "err_sum", longint'(sum_o[i]), m_sum[i]);
                chk(i, "err_max", longint'(max_o[i]), m_max[i]);
                chk(i, "err_cnt", longint'(cnt_o[i]), m_cnt[i]);
`ifdef PROD_ERR_SQ_EN
                chk(i, "err_sq_sum", longint'(sq_o[i]), m_sq[i]);
`endif
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic send(input int i, input int a, input int b, input int p);
        vld[i] = 1'b1; a_in[i] = 8'(a); b_in[i] = 8'(b); p_in[i] = 16'(p);
        cyc();
        vld[i] = 1'b0;
    endtask

    task automatic rand_send(input int i);
        int a = int'($urandom_range(255));
        int b = int'($urandom_range(255));
        int p;
        case ($urandom_range(3))
            0:       p = int'($urandom_range(65535));
            1:       p = a * b;
            2:       p = (a * b + int'($urandom_range(20))) & 16'hFFFF;
            default: p = (a * b >= 5) ? a * b - 5 : a * b;
        endcase
        while ($urandom_range(3) == 0) cyc();
        send(i, a, b, p);
    endtask

    // Waits for res_valid after the last accept and checks the latency.
    task automatic wait_res(input int i, input string nm);
        int k = 0;
        do begin
            cyc();
            k++;
        end while (!rvalid[i] && k <= 40);
        chk(i, {nm, "_latency"}, longint'(k), longint'(LAT));
    endtask

    task automatic lit(input int i, input string nm, input longint s, input longint m, input longint c);
        chk(i, {nm, "_sum"}, longint'(sum_o[i]), s);
        chk(i, {nm, "_max"}, longint'(max_o[i]), m);
        chk(i, {nm, "_cnt"}, longint'(cnt_o[i]), c);
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            vld[i] = 1'b0; clr[i] = 1'b0; rdy[i] = 1'b1;
            a_in[i] = '0; b_in[i] = '0; p_in[i] = '0;
            mreset(i);
        end
        repeat (3) cyc();
        lit(0, "reset", 0, 0, 0);
        chk(0, "reset_res_valid", longint'(rvalid[0]), 0);
        rst_n = 1'b1;
        cyc();

        // Exact multiplier
        send(0, 3, 5, 15); send(0, 255, 255, 65025); send(0, 0, 7, 0); send(0, 12, 34, 408);
        wait_res(0, "exact");
        lit(0, "exact", 0, 0, 0);
        cyc();

        // Known errors: +0, +1, -2, +7
        send(0, 10, 10, 100); send(0, 20, 3, 61); send(0, 7, 9, 61); send(0, 100, 200, 20007);
        wait_res(0, "known");
        lit(0, "known", 10, 7, 3);
        cyc();

        // Extremes on the two-sample window
        send(1, 0, 0, 16'hFFFF); send(1, 255, 255, 0);
        wait_res(1, "extreme");
        lit(1, "extreme", 130560, 65535, 2);
        cyc();

        // Backpressure: result held for 10 cycles, then released
        rdy[0] = 1'b0;
        send(0, 1, 1, 0); send(0, 2, 2, 4); send(0, 3, 3, 9); send(0, 4, 4, 20);
        wait_res(0, "bp");
        for (int c = 0; c < 10; c++) begin
            cyc();
            lit(0, "bp_hold", 5, 4, 2);
            chk(0, "bp_in_ready", longint'(iready[0]), 0);
        end
        rdy[0] = 1'b1;
        cyc();
        chk(0, "bp_release_valid", longint'(rvalid[0]), 0);
        lit(0, "bp_release", 0, 0, 0);
        send(0, 2, 3, 7); send(0, 5, 5, 25); send(0, 6, 6, 36); send(0, 9, 9, 81);
        wait_res(0, "bp_next");
        lit(0, "bp_next", 1, 1, 1);
        cyc();

        // Full 1024-sample window with random bubbles
        for (int s = 0; s < 1024; s++) rand_send(2);
        wait_res(2, "bubbles");
        cyc();

        // Clear after 500 samples; the sample offered with clear must be dropped
        for (int s = 0; s < 500; s++) rand_send(2);
        vld[2] = 1'b1; a_in[2] = 8'd200; b_in[2] = 8'd1; p_in[2] = 16'd0; clr[2] = 1'b1;
        cyc();
        vld[2] = 1'b0; clr[2] = 1'b0;
        repeat (5) cyc();
        chk(2, "clear_res_valid", longint'(rvalid[2]), 0);
        lit(2, "clear", 0, 0, 0);
        for (int s = 0; s < 1024; s++) rand_send(2);
        wait_res(2, "after_clear");
        cyc();

        // Asynchronous reset in the middle of a window
        send(0, 7, 7, 40); send(0, 8, 8, 1);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) mreset(i);
        lit(0, "async_rst", 0, 0, 0);
        chk(0, "async_rst_res_valid", longint'(rvalid[0]), 0);
        #1 rst_n = 1'b1;
        cyc();
        chk(0, "post_rst_in_ready", longint'(iready[0]), 1);
        send(0, 10, 10, 100); send(0, 20, 3, 61); send(0, 7, 9, 61); send(0, 100, 200, 20007);
        wait_res(0, "post_rst");
        lit(0, "post_rst", 10, 7, 3);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
